// File: rtl/gcd_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_sched_pkg
//  Desc     : Shared constants for the GCD request scheduler (state codes,
//             default sizing).
//  Revision : 1.0  initial release
// ============================================================================
package gcd_sched_pkg;

    localparam int c_DEF_NREQ  = 4;
    localparam int c_DEF_WIDTH = 16;
    localparam int c_ST_W      = 3;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_LOAD_A = 3'd2;
    localparam logic [2:0] c_ST_LOAD_B = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;
    localparam logic [2:0] c_ST_RESP   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/gcd_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_rr_arb
//  Desc     : Combinational round-robin pick: first set request at or after
//             the pointer, wrapping around.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    int w_j;

    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_req_sched
//  Desc     : Round-robin scheduler sharing one GCD engine among NREQ
//             requesters; optional WAIT timeout via GCD_SCHED_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_req_sched
    import gcd_sched_pkg::*;
#(
    parameter int NREQ        = c_DEF_NREQ,
    parameter int WIDTH       = c_DEF_WIDTH,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] opa,
    input  logic [NREQ*WIDTH-1:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_data,
    output logic                  eng_abort,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result
);

    localparam int c_IDX_W = $clog2(NREQ);

    logic [c_ST_W-1:0]  r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] r_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;

    logic               w_valid;
    logic [c_IDX_W-1:0] w_idx;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_tmo;

    gcd_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_a = opa[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b = opb[int'(w_idx)*WIDTH +: WIDTH];

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state != c_ST_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the last allowed WAIT cycle; a coincident eng_done wins.
    assign w_tmo = (r_state == c_ST_WAIT) && !eng_done &&
                   (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign w_tmo        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_valid) begin
                        r_idx <= w_idx;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_err <= 1'b0;
                        // The subtract-loop engine never terminates on zero.
                        if (w_a == '0 || w_b == '0) begin
                            r_result <= (w_a == '0) ? w_b : w_a;
                            r_state  <= c_ST_RESP;
                        end else begin
                            r_state  <= c_ST_START;
                        end
                    end
                end
                c_ST_START:  r_state <= c_ST_LOAD_A;
                c_ST_LOAD_A: r_state <= c_ST_LOAD_B;
                c_ST_LOAD_B: r_state <= c_ST_WAIT;
                c_ST_WAIT: begin
                    if (eng_done) begin
                        r_result <= eng_result;
                        r_state  <= c_ST_RESP;
                    end else if (w_tmo) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_state  <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_ptr   <= (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (r_state != c_ST_IDLE) begin
            gnt[r_idx] = 1'b1;
        end
        case (r_state)
            c_ST_LOAD_A: eng_data = r_a;
            c_ST_LOAD_B: eng_data = r_b;
            default:     eng_data = '0;
        endcase
    end

    assign eng_start = (r_state == c_ST_START);
    assign eng_abort = w_tmo;
    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_data  = rsp_valid ? r_result : '0;
    assign rsp_err   = rsp_valid & r_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_req_sched
//  Desc     : Directed self-checking bench for gcd_req_sched; the engine is
//             played by the bench with hand-computed GCD results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_req_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] opa;
    logic [NREQ*WIDTH-1:0] opb;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_data;
    logic                  eng_abort;
    logic                  eng_done;
    logic [WIDTH-1:0]      eng_result;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_req_sched #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .opa        (opa),
        .opb        (opb),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_abort  (eng_abort),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int r, input logic [15:0] a, input logic [15:0] b);
        opa[r*WIDTH +: WIDTH] = a;
        opb[r*WIDTH +: WIDTH] = b;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'h0);
        chk({tag, "_rv"},    32'(rsp_valid), 32'h0);
        chk({tag, "_rd"},    32'(rsp_data),  32'h0);
        chk({tag, "_rerr"},  32'(rsp_err),   32'h0);
        chk({tag, "_start"}, 32'(eng_start), 32'h0);
        chk({tag, "_edata"}, 32'(eng_data),  32'h0);
        chk({tag, "_abort"}, 32'(eng_abort), 32'h0);
    endtask

    // Called at an IDLE negedge with req already driven; r is the expected winner.
    // scr: after capture, drop req[r] and corrupt r's operands.
    task automatic op_eng(input string tag, input int r, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input bit scr);
        logic [NREQ-1:0] g;
        g = NREQ'(1) << r;
        tick();
        chk({tag, "_start"}, 32'(eng_start), 32'h1);
        chk({tag, "_gnt_s"}, 32'(gnt),       32'(g));
        chk({tag, "_ed0"},   32'(eng_data),  32'h0);
        if (scr) begin
            req[r] = 1'b0;
            set_ops(r, ~a, ~b);
        end
        tick();
        chk({tag, "_opa"},   32'(eng_data),  32'(a));
        chk({tag, "_st0"},   32'(eng_start), 32'h0);
        tick();
        chk({tag, "_opb"},   32'(eng_data),  32'(b));
        tick();
        chk({tag, "_wait_rv"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_gnt_w"},   32'(gnt),       32'(g));
        eng_done   = 1'b1;
        eng_result = res;
        tick();
        eng_done   = 1'b0;
        eng_result = '0;
        chk({tag, "_rv"},    32'(rsp_valid), 32'h1);
        chk({tag, "_rd"},    32'(rsp_data),  32'(res));
        chk({tag, "_rerr"},  32'(rsp_err),   32'h0);
        chk({tag, "_gnt_r"}, 32'(gnt),       32'(g));
        tick();
        chk({tag, "_idle_gnt"}, 32'(gnt),       32'h0);
        chk({tag, "_idle_rv"},  32'(rsp_valid), 32'h0);
    endtask

    // Zero-operand path: response one cycle after the request is sampled.
    task automatic op_zero(input string tag, input int r, input logic [15:0] res);
        tick();
        chk({tag, "_rv"},    32'(rsp_valid), 32'h1);
        chk({tag, "_rd"},    32'(rsp_data),  32'(res));
        chk({tag, "_gnt"},   32'(gnt),       32'(NREQ'(1) << r));
        chk({tag, "_start"}, 32'(eng_start), 32'h0);
        tick();
        chk({tag, "_idle"},  32'(gnt),       32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        opa        = '0;
        opb        = '0;
        eng_done   = 1'b0;
        eng_result = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single request: gcd(143,78)=13
        req = 4'b0001;
        set_ops(0, 16'd143, 16'd78);
        op_eng("single", 0, 16'd143, 16'd78, 16'd13, 1'b1);

        // All four requesting from ptr=0: served 0,1,2,3, gcd(48,18)=6
        do_reset();
        for (int r = 0; r < NREQ; r++) set_ops(r, 16'd48, 16'd18);
        req = 4'b1111;
        op_eng("rr0", 0, 16'd48, 16'd18, 16'd6, 1'b0);
        op_eng("rr1", 1, 16'd48, 16'd18, 16'd6, 1'b0);
        op_eng("rr2", 2, 16'd48, 16'd18, 16'd6, 1'b0);
        op_eng("rr3", 3, 16'd48, 16'd18, 16'd6, 1'b0);

        // Pointer wrapped to 0: requester 0 beats requester 3
        req = 4'b1001;
        set_ops(0, 16'd0, 16'd5);
        set_ops(3, 16'd0, 16'd9);
        op_zero("wrap", 0, 16'd5);
        req = '0;
        tick();

        // Zero operands on requester 2
        req = 4'b0100;
        set_ops(2, 16'd0, 16'd35);
        op_zero("zero_a", 2, 16'd35);
        req = '0;
        tick();
        req = 4'b0100;
        set_ops(2, 16'd0, 16'd0);
        op_zero("zero_ab", 2, 16'd0);
        req = '0;
        tick();
        req = 4'b0100;
        set_ops(2, 16'd12, 16'd0);
        op_zero("zero_b", 2, 16'd12);
        req = '0;

        // Spurious eng_done in IDLE is ignored
        eng_done   = 1'b1;
        eng_result = 16'd99;
        tick();
        eng_done   = 1'b0;
        eng_result = '0;
        chk("spur_rv",  32'(rsp_valid), 32'h0);
        chk("spur_gnt", 32'(gnt),       32'h0);

        // Requester 1 drops req and changes operands after capture: gcd(21,14)=7
        req = 4'b0010;
        set_ops(1, 16'd21, 16'd14);
        op_eng("frozen", 1, 16'd21, 16'd14, 16'd7, 1'b1);

        // Reset during WAIT abandons the operation
        req = 4'b0001;
        set_ops(0, 16'd9, 16'd6);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("rstw_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("rst_wait");
        tick();
        chk("rstw_norv", 32'(rsp_valid), 32'h0);
        req = 4'b0001;
        op_eng("after_rst", 0, 16'd9, 16'd6, 16'd3, 1'b1);

`ifdef GCD_SCHED_TIMEOUT_EN
        // Engine never finishes: abort after 16 WAIT cycles, then error response
        req = 4'b0001;
        set_ops(0, 16'd5, 16'd3);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("tmo_abort0", 32'(eng_abort), 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_abort1", 32'(eng_abort), 32'h1);
        chk("tmo_rv0",    32'(rsp_valid), 32'h0);
        tick();
        chk("tmo_abort2", 32'(eng_abort), 32'h0);
        chk("tmo_rv",     32'(rsp_valid), 32'h1);
        chk("tmo_err",    32'(rsp_err),   32'h1);
        chk("tmo_rd",     32'(rsp_data),  32'h0);
        tick();
        chk("tmo_idle",   32'(rsp_err),   32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_req_sched.md
# gcd_req_sched

Round-robin scheduler that shares one GCD engine (datapath + control path pair) between NREQ requesters. It arbitrates pending requests, captures the winner's operands, and sequences the engine's start/operand-load protocol. It waits for engine completion and returns the result with a one-cycle response pulse. Zero operands are resolved locally, because the subtract-loop engine never terminates on a zero input.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 16: operand/result width
- TIMEOUT_CYC, 1024: WAIT-state cycle limit (used only with GCD_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- opa  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- opb  in  NREQ*WIDTH  operand B, same packing
- gnt  out  NREQ  one-hot grant, held for the whole operation
- rsp_valid  out  1  one-cycle result pulse to the granted requester
- rsp_data  out  WIDTH  GCD result, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- eng_start  out  1  one-cycle start pulse to the engine
- eng_data  out  WIDTH  operand bus to the engine
- eng_abort  out  1  one-cycle engine abort on timeout
- eng_done  in  1  engine completion
- eng_result  in  WIDTH  engine GCD output, sampled with eng_done

## Operation
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - If any req is set, pick the first set bit at or after ptr (wrapping), register the index, and copy opa/opb into internal regs.
  - If either operand is 0, go to RESP with result = the other operand (GCD(0,0)=0).
  - Otherwise go to START.
- START: eng_start=1. LOAD_A: eng_data=A. LOAD_B: eng_data=B. Then go to WAIT.
- WAIT:
  - On eng_done=1, capture eng_result and go to RESP.
  - eng_done is ignored in every other state.
- RESP:
  - rsp_valid=1 and rsp_data=result.
  - ptr becomes index+1 (mod NREQ).
  - Return to IDLE.
- gnt is one-hot on the registered index from START (or RESP on the zero path) through RESP. It is 0 in IDLE.
- Operands are frozen at capture. Later changes on opa/opb, or deassertion of req, do not affect the operation; rsp_valid still pulses.
- A requester that keeps req high after its RESP is treated as a new request and competes in round-robin order.
- eng_data is 0 outside LOAD_A/LOAD_B.

## Timing
- Reset values:
  - State = IDLE, ptr = 0.
  - gnt, rsp_valid, rsp_err, eng_start, eng_abort = 0.
  - rsp_data, eng_data = 0.
- Reset mid-operation abandons the operation: no rsp_valid, and the engine is reset by the system reset.
- req sampled in IDLE at cycle t:
  - eng_start at t+1, A at t+2, B at t+3.
  - eng_done earliest at t+4, rsp_valid one cycle after eng_done.
- Zero-operand path: rsp_valid at t+1.
- Minimum gap between back-to-back operations is one IDLE cycle.
- A simultaneous req and rsp_valid for the same requester is not accepted until the following IDLE.

## Configuration
- GCD_SCHED_TIMEOUT_EN defined: a WAIT counter starts at 0 on entry. If it reaches TIMEOUT_CYC without eng_done:
  - eng_abort=1 for one cycle.
  - Go to RESP with rsp_err=1 and rsp_data=0.
- GCD_SCHED_TIMEOUT_EN undefined: no counter, WAIT is unbounded, and rsp_err and eng_abort are tied 0. Ports are unchanged.

## Structure
- Package gcd_sched_pkg holds the state encoding constants (IDLE=0 .. RESP=5) and the default WIDTH/NREQ constants.
- Sub-module gcd_rr_arb (NREQ): combinational round-robin pick from req and ptr. Outputs are a valid flag and a binary index.
- The FSM, operand registers and timeout counter live in the top.

## Test plan
- Single request, req0 with A=143, B=78 -> eng_start at t+1, eng_data 143 then 78, rsp_valid with rsp_data=13, gnt=0001 until RESP.
- All four requesting (each A=48, B=18) -> served in order 0,1,2,3, each rsp_data=6, no grant overlap, ptr wraps to 0.
- Zero operands: req2 A=0, B=35 -> rsp_data=35 at t+1 with no eng_start. A=0, B=0 -> rsp_data=0.
- req1 drops and opa changes mid-WAIT -> result still uses the captured operands, rsp_valid pulses. A spurious eng_done in IDLE is ignored.
- rst asserted during WAIT -> next cycle all outputs are 0 and state is IDLE. A fresh request then completes normally.
- With GCD_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, engine never asserts eng_done -> eng_abort pulse, then rsp_valid with rsp_err=1 and rsp_data=0.
